// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM control bit layout,
// default payload shape and control helpers.
package pipe_pkg;

  localparam int DEF_XLEN    = 64;
  localparam int DEF_RADDR_W = 5;

  localparam int CTRL_W        = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 0;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    adderout;
    logic [DEF_XLEN-1:0]    result;
    logic                   zero;
    logic [DEF_XLEN-1:0]    writedata;
    logic [DEF_RADDR_W-1:0] rd;
    logic [CTRL_W-1:0]      ctrl;
  } ex_mem_payload_t;

  // x0 is hardwired, so a write to it must never reach the regfile
  function automatic logic [CTRL_W-1:0] gate_ctrl(
    input logic [CTRL_W-1:0] ctrl,
    input logic              rd_is_x0
  );
    logic [CTRL_W-1:0] c;
    c = ctrl;
    if (rd_is_x0) c[CTRL_REGWRITE] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline slot over a flat payload,
// optionally backed by a second skid slot for a registered in_ready.
module pipe_skid_buf #(
  parameter int W    = 8,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         head_valid;
  logic [W-1:0] head;
  logic         in_xfer;
  logic         out_xfer;

  assign out_valid = head_valid;
  assign out_data  = head;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = head_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic         skid_valid;
      logic [W-1:0] skid;

      assign in_ready = ~skid_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          head_valid <= 1'b0;
          head       <= '0;
          skid_valid <= 1'b0;
          skid       <= '0;
        end else if (flush) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (!head_valid || out_xfer) begin
          // skid is older than anything on the input
          if (skid_valid) begin
            head       <= skid;
            head_valid <= 1'b1;
            skid_valid <= 1'b0;
          end else begin
            head_valid <= in_xfer;
            if (in_xfer) head <= in_data;
          end
        end else if (in_xfer) begin
          skid       <= in_data;
          skid_valid <= 1'b1;
        end
      end
    end else begin : g_reg
      assign in_ready = out_ready | ~head_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          head_valid <= 1'b0;
          head       <= '0;
        end else if (flush) begin
          head_valid <= 1'b0;
        end else if (in_xfer) begin
          head_valid <= 1'b1;
          head       <= in_data;
        end else if (out_xfer) begin
          head_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: flow-controlled register with x0 write
// suppression, bubble masking and a registered branch-taken flag.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_adderout,
  input  logic [XLEN-1:0]    in_result,
  input  logic               in_zero,
  input  logic [XLEN-1:0]    in_writedata,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [4:0]         in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_adderout,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_writedata,
  output logic               out_zero,
  output logic [RADDR_W-1:0] out_rd,
  output logic [4:0]         out_ctrl,
  output logic               out_pcsrc
);

  typedef struct packed {
    logic               taken;
    logic [XLEN-1:0]    adderout;
    logic [XLEN-1:0]    result;
    logic               zero;
    logic [XLEN-1:0]    writedata;
    logic [RADDR_W-1:0] rd;
    logic [CTRL_W-1:0]  ctrl;
  } entry_t;

  entry_t in_e;
  entry_t out_e;

  always_comb begin
    in_e           = '0;
    in_e.taken     = in_ctrl[CTRL_BRANCH] & in_zero;
    in_e.adderout  = in_adderout;
    in_e.result    = in_result;
    in_e.zero      = in_zero;
    in_e.writedata = in_writedata;
    in_e.rd        = in_rd;
    in_e.ctrl      = gate_ctrl(in_ctrl, in_rd == '0);
  end

  pipe_skid_buf #(
    .W    ($bits(entry_t)),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_e)
  );

  // stale data behind a bubble must look like a NOP
  assign out_adderout  = out_valid ? out_e.adderout  : '0;
  assign out_result    = out_valid ? out_e.result    : '0;
  assign out_writedata = out_valid ? out_e.writedata : '0;
  assign out_zero      = out_valid & out_e.zero;
  assign out_rd        = out_valid ? out_e.rd        : '0;
  assign out_ctrl      = out_valid ? out_e.ctrl      : '0;
  assign out_pcsrc     = out_valid & out_e.taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: SKID=1 and SKID=0 builds on shared
// stimulus, directed scenarios plus a randomized FIFO model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_adderout;
  logic [63:0] in_result;
  logic        in_zero;
  logic [63:0] in_writedata;
  logic [4:0]  in_rd;
  logic [4:0]  in_ctrl;
  logic        out_ready;

  logic        in_ready1, out_valid1, out_zero1, out_pcsrc1;
  logic [63:0] out_adderout1, out_result1, out_writedata1;
  logic [4:0]  out_rd1, out_ctrl1;

  logic        in_ready0, out_valid0, out_zero0, out_pcsrc0;
  logic [63:0] out_adderout0, out_result0, out_writedata0;
  logic [4:0]  out_rd0, out_ctrl0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] r;
    logic [63:0] w;
    logic        z;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
    logic        pc;
  } item_t;

  item_t q1[$];
  item_t q0[$];

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(64), .RADDR_W(5), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_adderout(in_adderout), .in_result(in_result),
    .in_zero(in_zero), .in_writedata(in_writedata),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_adderout(out_adderout1), .out_result(out_result1),
    .out_writedata(out_writedata1), .out_zero(out_zero1),
    .out_rd(out_rd1), .out_ctrl(out_ctrl1),
    .out_pcsrc(out_pcsrc1)
  );

  ex_mem_stage #(.XLEN(64), .RADDR_W(5), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_adderout(in_adderout), .in_result(in_result),
    .in_zero(in_zero), .in_writedata(in_writedata),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_adderout(out_adderout0), .out_result(out_result0),
    .out_writedata(out_writedata0), .out_zero(out_zero0),
    .out_rd(out_rd0), .out_ctrl(out_ctrl0),
    .out_pcsrc(out_pcsrc0)
  );

  task automatic drive(input logic v, input logic [63:0] r,
                       input logic [4:0] rd, input logic [4:0] c,
                       input logic z, input logic [63:0] a);
    in_valid     = v;
    in_result    = r;
    in_rd        = rd;
    in_ctrl      = c;
    in_zero      = z;
    in_adderout  = a;
    in_writedata = ~r;
  endtask

  // model: SKID=1 is a 2-deep FIFO accepting while not full;
  // SKID=0 is 1-deep accepting when empty or being drained
  task automatic cycle();
    item_t it;
    bit    rdy1, rdy0, pop1, pop0;
    it.a    = in_adderout;
    it.r    = in_result;
    it.w    = in_writedata;
    it.z    = in_zero;
    it.rd   = in_rd;
    it.ctrl = in_ctrl;
    if (in_rd == 5'd0) it.ctrl[0] = 1'b0;
    it.pc   = in_ctrl[4] & in_zero;
    if (reset || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      rdy1 = q1.size() < 2;
      rdy0 = (q0.size() == 0) || out_ready;
      pop1 = (q1.size() > 0) && out_ready;
      pop0 = (q0.size() > 0) && out_ready;
      if (pop1) void'(q1.pop_front());
      if (pop0) void'(q0.pop_front());
      if (in_valid && rdy1) q1.push_back(it);
      if (in_valid && rdy0) q0.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    flush     = 0;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    reset = 1;
    drive(1, 64'h77, 5'd3, 5'h1f, 1, 64'h88);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid1 !== 1'b0 || out_result1 !== 64'd0 ||
          out_ctrl1 !== 5'd0 || out_pcsrc1 !== 1'b0 ||
          out_adderout1 !== 64'd0 || out_rd1 !== 5'd0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b result=%h ctrl=%b pcsrc=%b, required all 0",
                 out_valid1, out_result1, out_ctrl1, out_pcsrc1);
      end
    end
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready1);
    end
  endtask

  task automatic test_stream();
    logic [63:0] vals [3];
    vals[0] = 64'h10;
    vals[1] = 64'h20;
    vals[2] = 64'h30;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, vals[i], 5'd1, 5'b00001, 0, 0);
      cycle();
      checks++;
      if (out_valid1 !== 1'b1 || out_result1 !== vals[i] ||
          in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b result=%h in_ready=%b, required 1 %h 1",
                 i, out_valid1, out_result1, in_ready1, vals[i]);
      end
    end
    drain();
  endtask

  task automatic test_stall_skid();
    out_ready = 0;
    drive(1, 64'hA, 5'd2, 5'b00001, 0, 0);
    cycle();
    checks++;
    if (out_result1 !== 64'hA || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL stall_a: result=%h in_ready=%b, required a 1",
               out_result1, in_ready1);
    end
    drive(1, 64'hB, 5'd2, 5'b00001, 0, 0);
    cycle();
    checks++;
    if (out_result1 !== 64'hA || in_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: result=%h in_ready=%b, required a 0",
               out_result1, in_ready1);
    end
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    cycle();
    checks++;
    if (out_valid1 !== 1'b1 || out_result1 !== 64'hB ||
        in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL stall_b: valid=%b result=%h in_ready=%b, required 1 b 1",
               out_valid1, out_result1, in_ready1);
    end
    cycle();
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: valid=%b required 0", out_valid1);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 64'h1A, 5'd2, 5'b10000, 1, 64'h500);
    cycle();
    checks++;
    if (out_pcsrc1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_pcsrc: got %b required 1", out_pcsrc1);
    end
    drive(1, 64'h1B, 5'd2, 5'b00011, 0, 0);
    cycle();
    flush = 1;
    drive(1, 64'hC, 5'd4, 5'b00001, 0, 0);
    cycle();
    flush = 0;
    checks++;
    if (out_valid1 !== 1'b0 || out_ctrl1 !== 5'd0 ||
        out_pcsrc1 !== 1'b0 || in_ready1 !== 1'b1 ||
        out_result1 !== 64'd0) begin
      errors++;
      $display("FAIL flush_skid1: valid=%b ctrl=%b pcsrc=%b in_ready=%b result=%h",
               out_valid1, out_ctrl1, out_pcsrc1, in_ready1, out_result1);
    end
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid0: valid=%b in_ready=%b, required 0 1",
               out_valid0, in_ready0);
    end
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
        errors++;
        $display("FAIL flush_dropped_%0d: valid1=%b valid0=%b result=%h, required 0",
                 i, out_valid1, out_valid0, out_result1);
      end
    end
  endtask

  task automatic test_x0_pcsrc();
    out_ready = 1;
    drive(1, 64'h11, 5'd0, 5'b00001, 0, 0);
    cycle();
    checks++;
    if (out_valid1 !== 1'b1 || out_ctrl1 !== 5'd0) begin
      errors++;
      $display("FAIL x0_suppress: valid=%b ctrl=%b, required 1 00000",
               out_valid1, out_ctrl1);
    end
    drive(1, 64'h12, 5'd3, 5'b00001, 0, 0);
    cycle();
    checks++;
    if (out_ctrl1 !== 5'b00001 || out_rd1 !== 5'd3) begin
      errors++;
      $display("FAIL x3_regwrite: ctrl=%b rd=%0d, required 00001 3",
               out_ctrl1, out_rd1);
    end
    drive(1, 64'h13, 5'd3, 5'b10000, 1, 64'h400);
    cycle();
    checks++;
    if (out_pcsrc1 !== 1'b1 || out_adderout1 !== 64'h400 ||
        out_ctrl1 !== 5'b10000) begin
      errors++;
      $display("FAIL pcsrc_taken: pcsrc=%b adderout=%h ctrl=%b, required 1 400 10000",
               out_pcsrc1, out_adderout1, out_ctrl1);
    end
    drive(1, 64'h14, 5'd3, 5'b10000, 0, 64'h400);
    cycle();
    checks++;
    if (out_pcsrc1 !== 1'b0) begin
      errors++;
      $display("FAIL pcsrc_not_taken: got %b required 0", out_pcsrc1);
    end
    drain();
  endtask

  task automatic test_skid0();
    out_ready = 0;
    drive(1, 64'h5A, 5'd1, 5'b00001, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (in_ready0 !== 1'b0 || out_result0 !== 64'h5A) begin
      errors++;
      $display("FAIL skid0_stall: in_ready=%b result=%h, required 0 5a",
               in_ready0, out_result0);
    end
    out_ready = 1;
    drive(1, 64'h5B, 5'd1, 5'b00001, 0, 0);
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL skid0_ready_comb: got %b required 1", in_ready0);
    end
    cycle();
    checks++;
    if (out_valid0 !== 1'b1 || out_result0 !== 64'h5B) begin
      errors++;
      $display("FAIL skid0_replace: valid=%b result=%h, required 1 5b",
               out_valid0, out_result0);
    end
    drain();
  endtask

  task automatic test_random();
    item_t e1, e0, zi;
    zi = '{a: 0, r: 0, w: 0, z: 0, rd: 0, ctrl: 0, pc: 0};
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            {$urandom, $urandom},
            5'($urandom_range(0, 3)),
            5'($urandom),
            1'($urandom),
            {$urandom, $urandom});
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      cycle();
      e1 = (q1.size() > 0) ? q1[0] : zi;
      e0 = (q0.size() > 0) ? q0[0] : zi;
      checks++;
      if (out_valid1 !== (q1.size() > 0) ||
          in_ready1 !== (q1.size() < 2)) begin
        errors++;
        $display("FAIL rnd1_flow_%0d: valid=%b in_ready=%b, model depth %0d",
                 i, out_valid1, in_ready1, q1.size());
      end
      checks++;
      if (out_result1 !== e1.r || out_adderout1 !== e1.a ||
          out_writedata1 !== e1.w || out_zero1 !== e1.z ||
          out_rd1 !== e1.rd || out_ctrl1 !== e1.ctrl ||
          out_pcsrc1 !== e1.pc) begin
        errors++;
        $display("FAIL rnd1_data_%0d: result=%h ctrl=%b pcsrc=%b, required %h %b %b",
                 i, out_result1, out_ctrl1, out_pcsrc1,
                 e1.r, e1.ctrl, e1.pc);
      end
      checks++;
      if (out_valid0 !== (q0.size() > 0) ||
          in_ready0 !== ((q0.size() == 0) || out_ready)) begin
        errors++;
        $display("FAIL rnd0_flow_%0d: valid=%b in_ready=%b, model depth %0d",
                 i, out_valid0, in_ready0, q0.size());
      end
      checks++;
      if (out_result0 !== e0.r || out_adderout0 !== e0.a ||
          out_writedata0 !== e0.w || out_zero0 !== e0.z ||
          out_rd0 !== e0.rd || out_ctrl0 !== e0.ctrl ||
          out_pcsrc0 !== e0.pc) begin
        errors++;
        $display("FAIL rnd0_data_%0d: result=%h ctrl=%b pcsrc=%b, required %h %b %b",
                 i, out_result0, out_ctrl0, out_pcsrc0,
                 e0.r, e0.ctrl, e0.pc);
      end
    end
    flush = 0;
  endtask

  initial begin
    reset     = 1;
    flush     = 0;
    out_ready = 0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush();
    test_x0_pcsrc();
    test_skid0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline boundary register with valid/ready flow control, synchronous flush, and an optional 2-entry skid buffer.
- Sits between ALU/branch-adder outputs and data memory / branch resolution.
- Lets the memory stage back-pressure EX without losing an in-flight instruction.
- Generalises the fixed 64-bit, always-advance EX/MEM register to any data width, with bubbles and stalls.

Parameters:
- XLEN, 64, width of adder output, ALU result and store data.
- RADDR_W, 5, destination register index width.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict/exception).
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_adderout  in  XLEN  branch target sum.
- in_result  in  XLEN  ALU result / memory address.
- in_zero  in  1  branch condition flag.
- in_writedata  in  XLEN  store data (forwarded rs2).
- in_rd  in  RADDR_W  destination register.
- in_ctrl  in  5  {branch, memread, memtoreg, memwrite, regwrite}, bit 4 = branch.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM consumes head this cycle.
- out_adderout, out_result, out_writedata  out  XLEN  head fields.
- out_zero  out  1  head zero flag.
- out_rd  out  RADDR_W  head destination.
- out_ctrl  out  5  head control bits, same ordering as in_ctrl.
- out_pcsrc  out  1  registered branch-taken: head branch & zero & valid.

Behaviour:
- Clocking: single clock domain.
- Reset: synchronous, active-high; polarity and synchronicity are fixed. All out_* = 0, out_valid = 0, out_pcsrc = 0, skid entry invalid.
- in_ready after reset: 1 when SKID=1; equals out_ready | ~out_valid when SKID=0.
- Transfer rules: in transfer = in_valid & in_ready; out transfer = out_valid & out_ready. Latency in to out is 1 cycle when the head is empty or draining.
- Control gating: an accepted entry stores ctrl with regwrite forced to 0 when in_rd == 0 (x0 writes suppressed). Output fields of an invalid head read as all-zero; all control bits are 0 whenever out_valid = 0, so bubbles are safe NOPs.
- SKID=1, two storage slots: head (drives outputs) and skid.
  - in_ready = ~skid_valid, registered.
  - Head empty or out transfer, skid empty: input loads head.
  - Head full, no out transfer, in transfer: input loads skid; in_ready falls next cycle.
  - Out transfer with skid full: skid moves to head, skid empties, in_ready rises next cycle. The concurrent input cannot arrive, since in_ready was 0.
  - Head and skid never reorder; FIFO order holds.
- SKID=0, single head slot.
  - Loads on in transfer.
  - Clears valid on an out transfer without an in transfer.
  - A simultaneous out and in transfer replaces the head with no bubble.
- Flush:
  - Wins over all other events in the same cycle.
  - Next cycle: out_valid = 0, skid empty, control bits 0, out_pcsrc = 0. Data fields may hold stale values but are masked to 0 on the outputs.
  - An input presented in the flush cycle is dropped.
  - in_ready = 1 the cycle after a flush, for both SKID settings.
- Reset vs flush: reset has priority; reset mid-stall discards both slots.
- Data handling: no arithmetic; widths pass through unchanged. out_pcsrc is registered alongside the head and is not recomputed combinationally.

Decomposition:
- Shared package pipe_pkg: ctrl field index constants (CTRL_BRANCH = 4 … CTRL_REGWRITE = 0), CTRL_W = 5, a packed ex_mem_payload_t struct {adderout, result, zero, writedata, rd, ctrl} sized from XLEN and RADDR_W.
- Sub-module pipe_skid_buf: generic valid/ready 2-slot buffer over a packed payload, with flush. It is reused for ID/EX and MEM/WB.
- ex_mem_stage wraps pipe_skid_buf and adds the x0 regwrite suppression, output masking and the pcsrc register.

Test Plan:
- Reset behaviour: hold reset 3 cycles with in_valid = 1 -> out_valid = 0, all outputs 0, then in_ready = 1 (SKID=1) on release.
- Streaming: out_ready = 1, push result = 0x10, 0x20, 0x30 on consecutive cycles -> same values on out_result one cycle later each, no bubbles, in_ready stays 1.
- Stall into skid: push A (result = 0xA), B (0xB) with out_ready = 0 -> head = A and skid = B, in_ready = 0. Raise out_ready -> A then B appear in order, and in_ready returns to 1 one cycle after A leaves.
- Flush during a full stall: head and skid full; assert flush together with in_valid = 1 (result = 0xC) -> next cycle out_valid = 0, out_ctrl = 0, out_pcsrc = 0, and 0xC is never emitted.
- x0 suppression and pcsrc: push rd = 0, ctrl = 5'b00001 -> out_ctrl = 0. Push rd = 3, ctrl = 5'b10000, zero = 1, adderout = 0x400 -> out_pcsrc = 1, out_adderout = 0x400.
- SKID=0 build: out_ready = 0 with head full -> in_ready = 0. Same-cycle out and in transfer -> head replaced with no bubble.
